vpu_fp_addn: RTL and testbench
==============================

# vpu_fp_addn

Parametrised N-operand floating-point sum/difference unit for the VPU execution stage. It is the generalised successor of the fixed 3-operand adder. It latches up to NUM_OPERANDS source operands on start, then chains them through one shared floating_point_add_sub instance, one operand per pass. It applies a per-operand negate mask and returns a single registered result with a one-cycle done pulse to the destination port.

## Interface
- DATA_WIDTH, 32: IEEE-754 operand and result width; the sign bit is bit DATA_WIDTH-1.
- NUM_OPERANDS, 4: maximum operand count; legal range 2..8.
- ADD_LATENCY, 11: fixed latency of the floating_point_add_sub instance, in cycles. Must match the IP configuration.
- CW, $clog2(NUM_OPERANDS)+1: width of op_cnt_i. Derived; not overridden.
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- operands_i  in  NUM_OPERANDS*DATA_WIDTH  operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- op_cnt_i  in  CW  number of operands to sum.
- sub_mask_i  in  NUM_OPERANDS  bit k=1 negates operand k before summing.
- result_o  out  DATA_WIDTH  registered result; held until the next done.
- done_o  out  1  one-cycle pulse; result_o is valid in the same cycle.
- busy_o  out  1  high whenever the unit is not in IDLE.

## Operation
- States: DRAIN, IDLE, ISSUE, WAIT.
- Asynchronous reset:
  - state=DRAIN, drain counter=0.
  - result_o=0, done_o=0, busy_o=1, internal index and accumulator=0.
- DRAIN:
  - Counts ADD_LATENCY cycles, then goes to IDLE.
  - Purpose: flush any in-flight IP result. The IP has no reset.
  - start_i is ignored.
- IDLE, when start_i=1:
  - Latch each operand k with sign bit XORed by sub_mask_i[k].
  - Latch n = op_cnt_i clamped to [2, NUM_OPERANDS].
  - Set idx=1 and go to ISSUE.
- ISSUE:
  - Drive IP tvalid=1 for one cycle.
  - a = operand0 when idx=1, otherwise acc; b = operand[idx]; operation tdata=0 (add).
  - Go to WAIT.
- WAIT, on result_tvalid:
  - acc ← result_tdata.
  - If idx=n-1: result_o ← result_tdata, done_o pulses next cycle, go to IDLE.
  - Otherwise: idx ← idx+1, go to ISSUE.
- result_tvalid is ignored in DRAIN, IDLE and ISSUE. No spurious done is ever produced.
- start_i is ignored outside IDLE. Operands are not re-sampled during an operation, so the source may change them after the start cycle.
- Summation order is fixed left-to-right: ((op0+op1)+op2)+…. Rounding, NaN and Inf behaviour follow the IP per step.
- busy_o = (state≠IDLE), registered. It falls in the same cycle done_o rises.

## Timing
- Cycle 0 is the cycle in which start_i is sampled high in IDLE.
- Each pass takes ADD_LATENCY+1 cycles: one ISSUE cycle plus ADD_LATENCY cycles in WAIT.
- done_o is high in cycle (n-1)*(ADD_LATENCY+1)+1.
  - With defaults and n=4: cycle 37.
  - With n=2: cycle 13.
- busy_o is high in cycles 1 through done-1.
- Back-to-back: start_i high in the done_o cycle is accepted. No idle gap is required.
- After rst_n deasserts, busy_o stays high for ADD_LATENCY cycles (DRAIN). The first start is accepted in the following cycle.
- Reset mid-operation aborts immediately: no done_o, result_o=0, and DRAIN restarts.

## Test plan
- Sum of four: operands 1.0/2.0/3.0/4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), op_cnt_i=4, mask=0 → done_o single pulse at cycle 37, result_o=0x41200000. busy_o is 1 in cycles 1–36.
- Subtract and minimum count: op0=5.0 (0x40A00000), op1=3.0, op_cnt_i=2, mask=0b0010 → done_o at cycle 13, result_o=0x40000000. Repeat with op_cnt_i=0 → same result (clamped to 2).
- Clamp to maximum: op_cnt_i=7 with 1.0/2.0/3.0/4.0 → behaves as n=4, result_o=0x41200000 at cycle 37.
- Latching and busy: change operands_i to garbage after cycle 0, and pulse start_i during WAIT → result_o unchanged at 0x41200000, exactly one done_o.
- Back-to-back: second start (1.0+1.0, n=2) asserted in the first done cycle → second done_o exactly 13 cycles later with result_o=0x40000000. The first result is held in between.
- Reset mid-op: assert rst_n=0 during the second pass of the n=4 case, then release → no done_o. busy_o=1 for 11 cycles after release. The stale IP result arriving during DRAIN is ignored. A following n=2 op gives the correct result.

Source files
------------

// File: rtl/floating_point_add_sub.sv
// Behavioural stand-in for the vendor floating-point add/sub core: IEEE round-to-nearest-even,
// fixed LATENCY-stage pipeline, no reset, operation tdata 8'h01 selects subtract.
module floating_point_add_sub #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 11
) (
  input  logic                  aclk,
  input  logic                  s_axis_a_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_a_tdata,
  input  logic                  s_axis_b_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_b_tdata,
  input  logic                  s_axis_operation_tvalid,
  input  logic [7:0]            s_axis_operation_tdata,
  output logic                  m_axis_result_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_result_tdata
);

  localparam int EW = (DATA_WIDTH == 64) ? 11 : (DATA_WIDTH == 16) ? 5 : 8;
  localparam int MW = DATA_WIDTH - EW - 1;
  localparam int W  = MW + 4;

  logic                  sa, sb, eff_sub, a_big, big_s;
  logic                  a_nan, b_nan, a_inf, b_inf;
  logic [EW-1:0]         ea, eb, big_e, small_e, big_ee, small_ee;
  logic [MW-1:0]         fa, fb;
  logic [W-1:0]          big_m, small_m, small_al, norm_m;
  logic [2*W-1:0]        wide;
  logic [W:0]            sum;
  logic [EW+1:0]         exp_n;
  logic [MW+1:0]         rnd;
  logic [DATA_WIDTH-1:0] res;
  int                    diff, lz, sh;

  logic [DATA_WIDTH-1:0] pipe_d [LATENCY];
  logic [LATENCY-1:0]    pipe_v;

  // Subnormals use exponent 1 with a zero hidden bit; the smaller operand keeps a sticky bit.
  always_comb begin
    sa       = s_axis_a_tdata[DATA_WIDTH-1];
    sb       = s_axis_b_tdata[DATA_WIDTH-1] ^ (s_axis_operation_tdata == 8'h01);
    ea       = s_axis_a_tdata[DATA_WIDTH-2 -: EW];
    eb       = s_axis_b_tdata[DATA_WIDTH-2 -: EW];
    fa       = s_axis_a_tdata[MW-1:0];
    fb       = s_axis_b_tdata[MW-1:0];
    a_nan    = (&ea) && (|fa);
    b_nan    = (&eb) && (|fb);
    a_inf    = (&ea) && !(|fa);
    b_inf    = (&eb) && !(|fb);
    a_big    = s_axis_a_tdata[DATA_WIDTH-2:0] >= s_axis_b_tdata[DATA_WIDTH-2:0];
    big_s    = a_big ? sa : sb;
    eff_sub  = sa ^ sb;
    big_e    = a_big ? ea : eb;
    small_e  = a_big ? eb : ea;
    big_ee   = big_e | EW'(big_e == '0);
    small_ee = small_e | EW'(small_e == '0);
    big_m    = a_big ? {|ea, fa, 3'b000} : {|eb, fb, 3'b000};
    small_m  = a_big ? {|eb, fb, 3'b000} : {|ea, fa, 3'b000};

    diff = int'(big_ee) - int'(small_ee);
    if (diff > W) diff = W;
    wide     = {small_m, {W{1'b0}}} >> diff;
    small_al = wide[2*W-1:W] | W'(|wide[W-1:0]);
    sum      = eff_sub ? ({1'b0, big_m} - {1'b0, small_al}) : ({1'b0, big_m} + {1'b0, small_al});

    exp_n = {2'b00, big_ee};
    sh    = 0;
    lz    = W;
    for (int i = 0; i < W; i++) if (sum[i]) lz = W - 1 - i;
    if (sum[W]) begin
      norm_m = sum[W:1] | W'(sum[0]);
      exp_n  = exp_n + (EW+2)'(1);
    end else begin
      sh     = (lz < int'(big_ee) - 1) ? lz : int'(big_ee) - 1;
      norm_m = sum[W-1:0] << sh;
      exp_n  = exp_n - (EW+2)'(sh);
    end

    rnd = {1'b0, norm_m[W-1:3]} + (MW+2)'(norm_m[2] & (norm_m[3] | norm_m[1] | norm_m[0]));
    if (rnd[MW+1]) begin
      exp_n = exp_n + (EW+2)'(1);
      rnd   = rnd >> 1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
      res = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    else if (a_inf || b_inf)
      res = {a_inf ? sa : sb, {EW{1'b1}}, {MW{1'b0}}};
    else if (sum == '0)
      res = {sa & sb, {(DATA_WIDTH-1){1'b0}}};
    else if (rnd[MW] && (exp_n >= (EW+2)'((1 << EW) - 1)))
      res = {big_s, {EW{1'b1}}, {MW{1'b0}}};
    else
      res = {big_s, rnd[MW] ? exp_n[EW-1:0] : {EW{1'b0}}, rnd[MW-1:0]};
  end

  always_ff @(posedge aclk) begin
    pipe_v[0] <= s_axis_a_tvalid & s_axis_b_tvalid & s_axis_operation_tvalid;
    pipe_d[0] <= res;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign m_axis_result_tvalid = pipe_v[LATENCY-1];
  assign m_axis_result_tdata  = pipe_d[LATENCY-1];

endmodule

// File: rtl/vpu_fp_addn.sv
// N-operand floating-point sum/difference: latches operands with a negate mask and folds them
// left-to-right through one shared adder, one operand per pass.
module vpu_fp_addn #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_OPERANDS = 4,
  parameter int ADD_LATENCY  = 11,
  parameter int CW           = $clog2(NUM_OPERANDS) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [NUM_OPERANDS*DATA_WIDTH-1:0] operands_i,
  input  logic [CW-1:0]                  op_cnt_i,
  input  logic [NUM_OPERANDS-1:0]        sub_mask_i,
  output logic [DATA_WIDTH-1:0]          result_o,
  output logic                           done_o,
  output logic                           busy_o
);

  localparam int IW  = CW - 1;
  localparam int DCW = $clog2(ADD_LATENCY + 1);

  typedef enum logic [1:0] {DRAIN, IDLE, ISSUE, WAIT} state_t;

  state_t                state;
  logic [DCW-1:0]        drain_cnt;
  logic [DATA_WIDTH-1:0] ops [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] acc;
  logic [CW-1:0]         n, n_clamped;
  logic [IW-1:0]         idx;
  logic                  ip_valid, ip_res_valid;
  logic [DATA_WIDTH-1:0] ip_a, ip_b, ip_res;

  always_comb begin
    if (op_cnt_i < CW'(2))                 n_clamped = CW'(2);
    else if (op_cnt_i > CW'(NUM_OPERANDS)) n_clamped = CW'(NUM_OPERANDS);
    else                                   n_clamped = op_cnt_i;
  end

  assign ip_valid = (state == ISSUE);
  assign ip_a     = (idx == IW'(1)) ? ops[0] : acc;
  assign ip_b     = ops[idx];

  floating_point_add_sub #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (ADD_LATENCY)
  ) u_add (
    .aclk                    (clk),
    .s_axis_a_tvalid         (ip_valid),
    .s_axis_a_tdata          (ip_a),
    .s_axis_b_tvalid         (ip_valid),
    .s_axis_b_tdata          (ip_b),
    .s_axis_operation_tvalid (ip_valid),
    .s_axis_operation_tdata  (8'h00),
    .m_axis_result_tvalid    (ip_res_valid),
    .m_axis_result_tdata     (ip_res)
  );

  // The adder has no reset, so DRAIN waits out one full latency before accepting work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DRAIN;
      drain_cnt <= '0;
      result_o  <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b1;
      idx       <= '0;
      acc       <= '0;
      n         <= '0;
      for (int k = 0; k < NUM_OPERANDS; k++) ops[k] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        DRAIN: begin
          if (drain_cnt == DCW'(ADD_LATENCY - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        IDLE: begin
          if (start_i) begin
            for (int k = 0; k < NUM_OPERANDS; k++)
              ops[k] <= operands_i[k*DATA_WIDTH +: DATA_WIDTH] ^ {sub_mask_i[k], {(DATA_WIDTH-1){1'b0}}};
            n      <= n_clamped;
            idx    <= IW'(1);
            state  <= ISSUE;
            busy_o <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (ip_res_valid) begin
            acc <= ip_res;
            if ({1'b0, idx} == n - CW'(1)) begin
              result_o <= ip_res;
              done_o   <= 1'b1;
              busy_o   <= 1'b0;
              state    <= IDLE;
            end else begin
              idx   <= idx + IW'(1);
              state <= ISSUE;
            end
          end
        end
        default: state <= DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_fp_addn.sv
// Bench for vpu_fp_addn: directed cases plus random small-integer sums checked against an
// integer reference whose totals are exactly representable in single precision.
module tb_vpu_fp_addn;

  localparam int DW  = 32;
  localparam int NOP = 4;
  localparam int LAT = 11;
  localparam int CW  = $clog2(NOP) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [NOP*DW-1:0] operands_i;
  logic [CW-1:0]     op_cnt_i;
  logic [NOP-1:0]    sub_mask_i;
  logic [DW-1:0]     result_o;
  logic              done_o;
  logic              busy_o;

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] last_res;

  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000,
                          F4 = 32'h40800000, F5 = 32'h40A00000, F10 = 32'h41200000;

  vpu_fp_addn #(.DATA_WIDTH(DW), .NUM_OPERANDS(NOP), .ADD_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .operands_i (operands_i),
    .op_cnt_i   (op_cnt_i),
    .sub_mask_i (sub_mask_i),
    .result_o   (result_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] int2fp(input int v);
    int m, p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (((m >> i) & 1) != 0) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h007FFFFF);
    return r;
  endfunction

  function automatic int clamp_n(input int cnt);
    return (cnt < 2) ? 2 : (cnt > NOP) ? NOP : cnt;
  endfunction

  task automatic apply_stimulus(input logic [NOP*DW-1:0] ops, input int cnt, input logic [NOP-1:0] mask);
    operands_i = ops;
    op_cnt_i   = CW'(cnt);
    sub_mask_i = mask;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  // Called in cycle 1 of an operation; returns in the done cycle.
  task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_res,
                           input logic [31:0] held, input bit disturb);
    int c = 1;
    int bad_busy = 0;
    int bad_hold = 0;
    bit seen = 0;
    while (!seen && c <= 100) begin
      if (done_o) seen = 1;
      else begin
        if (busy_o !== 1'b1) bad_busy++;
        if (result_o !== held) bad_hold++;
        if (disturb && c == 3) operands_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_i = disturb && (c == 20);
        tick();
        c++;
      end
    end
    start_i = 1'b0;
    check_output({tag, " done_seen"}, 32'(seen), 32'd1);
    check_output({tag, " done_cycle"}, 32'(c), 32'(exp_cyc));
    check_output({tag, " result"}, result_o, exp_res);
    check_output({tag, " busy_at_done"}, 32'(busy_o), 32'd0);
    check_output({tag, " busy_gaps"}, 32'(bad_busy), 32'd0);
    check_output({tag, " result_held"}, 32'(bad_hold), 32'd0);
    last_res = exp_res;
  endtask

  task automatic check_drain(input string tag);
    int c = 0;
    bit done_seen = 0;
    while (busy_o && c < 40) begin
      tick();
      c++;
      if (done_o) done_seen = 1;
    end
    check_output({tag, " drain_cycles"}, 32'(c), 32'(LAT));
    check_output({tag, " drain_no_done"}, 32'(done_seen), 32'd0);
  endtask

  task automatic check_single_pulse(input string tag);
    tick();
    check_output({tag, " done_single"}, 32'(done_o), 32'd0);
    check_output({tag, " idle_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [NOP*DW-1:0] ops;
    int vals [NOP];
    int cnt, n, sum;
    logic [NOP-1:0] mask;

    rst_n = 1'b0; start_i = 1'b0; operands_i = '0; op_cnt_i = '0; sub_mask_i = '0;
    last_res = '0;
    repeat (3) tick();
    check_output("reset result", result_o, 32'h0);
    check_output("reset done", 32'(done_o), 32'd0);
    check_output("reset busy", 32'(busy_o), 32'd1);
    rst_n = 1'b1;
    check_drain("power-up");

    apply_stimulus({F4, F3, F2, F1}, 4, 4'b0000);
    wait_done("sum4", 37, F10, last_res, 1'b0);
    check_single_pulse("sum4");

    apply_stimulus({32'h0, 32'h0, F3, F5}, 2, 4'b0010);
    wait_done("sub2", 13, F2, last_res, 1'b0);
    apply_stimulus({32'h0, 32'h0, F3, F5}, 0, 4'b0010);
    wait_done("sub_cnt0", 13, F2, last_res, 1'b0);

    apply_stimulus({F4, F3, F2, F1}, 7, 4'b0000);
    wait_done("clamp7", 37, F10, last_res, 1'b0);

    apply_stimulus({F4, F3, F2, F1}, 4, 4'b0000);
    wait_done("latch", 37, F10, last_res, 1'b1);
    check_single_pulse("latch");

    apply_stimulus({F4, F1, F2, F3}, 3, 4'b0100);
    wait_done("pre_b2b", 25, F4, last_res, 1'b0);
    apply_stimulus({32'h0, 32'h0, F1, F1}, 2, 4'b0000);
    wait_done("b2b", 13, F2, last_res, 1'b0);

    apply_stimulus({F4, F3, F2, F1}, 4, 4'b0000);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check_output("midreset result", result_o, 32'h0);
    check_output("midreset done", 32'(done_o), 32'd0);
    check_output("midreset busy", 32'(busy_o), 32'd1);
    last_res = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    check_drain("midreset");
    apply_stimulus({32'h0, 32'h0, F3, F5}, 2, 4'b0010);
    wait_done("post_reset", 13, F2, last_res, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < NOP; k++) begin
        vals[k] = int'($urandom_range(2000)) - 1000;
        if (vals[k] == 0) vals[k] = 1;
        ops[k*DW +: DW] = int2fp(vals[k]);
      end
      cnt  = int'($urandom_range(7));
      mask = NOP'($urandom_range(15));
      n    = clamp_n(cnt);
      sum  = 0;
      for (int k = 0; k < n; k++) sum += mask[k] ? -vals[k] : vals[k];
      apply_stimulus(ops, cnt, mask);
      wait_done($sformatf("rand%0d", t), (n - 1) * (LAT + 1) + 1, int2fp(sum), last_res, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
